// File: rtl/lr35902_bg_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lr35902_bg_fetch
//  Description : PPU background tile fetcher. Walks one scanline of the BG
//                map and hands each tile's 8-pixel bitplane row downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module lr35902_bg_fetch #(
    parameter int TILES_PER_LINE = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic        map_sel,
    input  logic        data_sel,
    output logic [12:0] vram_adr,
    output logic        vram_read,
    input  logic [7:0]  vram_dout,
    output logic [7:0]  out_lo,
    output logic [7:0]  out_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        line_done
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_MAP  = 3'd1;
    localparam logic [2:0] c_ST_LO   = 3'd2;
    localparam logic [2:0] c_ST_HI   = 3'd3;
    localparam logic [2:0] c_ST_CAP  = 3'd4;
    localparam logic [2:0] c_ST_OUT  = 3'd5;

    localparam logic [4:0] c_LAST_X = 5'(TILES_PER_LINE - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [4:0]  r_x;
    logic [4:0]  r_x0;
    logic [7:0]  r_y;
    logic        r_map_sel;
    logic        r_data_sel;
    logic [7:0]  r_tile;
    logic [7:0]  r_lo;
    logic [7:0]  r_out_lo;
    logic [7:0]  r_out_hi;
    logic        r_out_valid;
    logic        r_line_done;
    logic [12:0] r_adr_hold;

    logic        w_read;
    logic [12:0] w_adr;
    logic [4:0]  w_col;
    logic [7:0]  w_tile;
    logic [12:0] w_map_adr;
    logic [12:0] w_data_adr;
    logic        w_handshake;
    logic        w_last;
    logic        w_unused_ok;

    // Fine horizontal scroll is applied by the pixel pipeline, not here.
    assign w_unused_ok = &{1'b0, scx[2:0]};

    assign w_col       = r_x0 + r_x;
    assign w_map_adr   = {2'b11, r_map_sel, r_y[7:3], w_col};
    // In LO the tile number is still on the read bus; afterwards it is held.
    assign w_tile      = (r_state == c_ST_LO) ? vram_dout : r_tile;
    assign w_data_adr  = {(r_data_sel ? 1'b0 : ~w_tile[7]), w_tile, r_y[2:0],
                          (r_state == c_ST_HI)};
    assign w_handshake = (r_state == c_ST_OUT) && r_out_valid && out_ready;
    assign w_last      = (r_x == c_LAST_X);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = c_ST_MAP;
        end else begin
            case (r_state)
                c_ST_IDLE: w_next_state = c_ST_IDLE;
                c_ST_MAP:  w_next_state = c_ST_LO;
                c_ST_LO:   w_next_state = c_ST_HI;
                c_ST_HI:   w_next_state = c_ST_CAP;
                c_ST_CAP:  w_next_state = c_ST_OUT;
                c_ST_OUT: begin
                    if (w_handshake) begin
                        w_next_state = w_last ? c_ST_IDLE : c_ST_MAP;
                    end
                end
                default:   w_next_state = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_read = 1'b0;
        w_adr  = r_adr_hold;
        case (r_state)
            c_ST_MAP: begin
                w_read = 1'b1;
                w_adr  = w_map_adr;
            end
            c_ST_LO, c_ST_HI: begin
                w_read = 1'b1;
                w_adr  = w_data_adr;
            end
            default: begin
                w_read = 1'b0;
                w_adr  = r_adr_hold;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= 5'd0;
            r_x0        <= 5'd0;
            r_y         <= 8'd0;
            r_map_sel   <= 1'b0;
            r_data_sel  <= 1'b0;
            r_tile      <= 8'd0;
            r_lo        <= 8'd0;
            r_out_lo    <= 8'd0;
            r_out_hi    <= 8'd0;
            r_out_valid <= 1'b0;
            r_line_done <= 1'b0;
            r_adr_hold  <= 13'd0;
        end else begin
            r_line_done <= 1'b0;
            if (w_read) begin
                r_adr_hold <= w_adr;
            end
            if (start) begin
                r_y         <= ly + scy;
                r_x0        <= scx[7:3];
                r_map_sel   <= map_sel;
                r_data_sel  <= data_sel;
                r_x         <= 5'd0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_LO:  r_tile <= vram_dout;
                    c_ST_HI:  r_lo   <= vram_dout;
                    c_ST_CAP: begin
                        r_out_hi    <= vram_dout;
                        r_out_lo    <= r_lo;
                        r_out_valid <= 1'b1;
                    end
                    c_ST_OUT: begin
                        if (w_handshake) begin
                            r_out_valid <= 1'b0;
                            if (w_last) begin
                                r_line_done <= 1'b1;
                            end else begin
                                r_x <= r_x + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vram_adr  = w_adr;
    assign vram_read = w_read;
    assign out_lo    = r_out_lo;
    assign out_hi    = r_out_hi;
    assign out_valid = r_out_valid;
    assign line_done = r_line_done;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lr35902_bg_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lr35902_bg_fetch
//  Description : Scoreboard bench for the BG fetcher with a registered VRAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lr35902_bg_fetch;

    localparam int TPL = 21;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  ly = 8'd0;
    logic [7:0]  scx = 8'd0;
    logic [7:0]  scy = 8'd0;
    logic        map_sel = 1'b0;
    logic        data_sel = 1'b1;
    logic [12:0] vram_adr;
    logic        vram_read;
    logic [7:0]  vram_dout = 8'd0;
    logic [7:0]  out_lo;
    logic [7:0]  out_hi;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        line_done;

    logic [7:0]  mem [0:8191];
    logic [12:0] exp_rd [$];
    logic [7:0]  exp_lo [$];
    logic [7:0]  exp_hi [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_ld = 0;
    int          ld0;

    lr35902_bg_fetch #(.TILES_PER_LINE(TPL)) dut (
        .clk(clk), .reset(reset), .start(start), .ly(ly), .scx(scx), .scy(scy),
        .map_sel(map_sel), .data_sel(data_sel), .vram_adr(vram_adr),
        .vram_read(vram_read), .vram_dout(vram_dout), .out_lo(out_lo),
        .out_hi(out_hi), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    // Registered VRAM: data for a read strobed in cycle n appears in cycle n+1.
    always @(posedge clk) begin
        if (vram_read) vram_dout <= mem[vram_adr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [7:0] l, input logic [7:0] sx,
                             input logic [7:0] sy, input logic m, input logic d);
        logic [7:0]  y;
        logic [7:0]  t;
        logic [4:0]  x0;
        logic [4:0]  col;
        logic [12:0] ma;
        logic [12:0] la;
        y  = l + sy;
        x0 = sx[7:3];
        for (int x = 0; x < TPL; x++) begin
            col = x0 + 5'(x);
            ma  = {2'b11, m, y[7:3], col};
            t   = mem[ma];
            la  = {(d ? 1'b0 : ~t[7]), t, y[2:0], 1'b0};
            exp_rd.push_back(ma);
            exp_rd.push_back(la);
            exp_rd.push_back(la | 13'd1);
            exp_lo.push_back(mem[la]);
            exp_hi.push_back(mem[la | 13'd1]);
        end
    endtask

    // Returns in cycle 1 of the new line; inputs are scrambled afterwards.
    task automatic start_line(input logic [7:0] l, input logic [7:0] sx,
                              input logic [7:0] sy, input logic m, input logic d);
        ly = l; scx = sx; scy = sy; map_sel = m; data_sel = d;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_rd.delete(); exp_lo.delete(); exp_hi.delete();
        push_line(l, sx, sy, m, d);
        ly = ~l; scx = ~sx; scy = sy + 8'd77; map_sel = ~m; data_sel = ~d;
    endtask

    task automatic line_end(input int ld_start);
        for (int i = 0; i < 400 && busy; i++) tick(1);
        chk("line_idle", 32'(busy), 32'd0);
        tick(1);
        chk("line_done_count", 32'(n_ld - ld_start), 32'd1);
        chk("sb_drain", 32'(exp_rd.size() + exp_lo.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (vram_read) begin
                if (exp_rd.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_unexpected: got read of %h, required no read", vram_adr);
                end else begin
                    chk("rd_adr", 32'(vram_adr), 32'(exp_rd.pop_front()));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_lo.size() == 0) begin
                    n_total++;
                    $display("FAIL row_unexpected: got row %h/%h, required none", out_lo, out_hi);
                end else begin
                    chk("row_lo", 32'(out_lo), 32'(exp_lo.pop_front()));
                    chk("row_hi", 32'(out_hi), 32'(exp_hi.pop_front()));
                end
            end
            if (line_done) n_ld++;
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 37) ^ (i >> 7));
        mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hAA; mem[13'h0051] = 8'h55;
        mem[13'h1C20] = 8'h80; mem[13'h1C21] = 8'h7F;
        mem[13'h18C7] = 8'h12;

        tick(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(vram_read), 32'd0);
        chk("rst_adr", 32'(vram_adr), 32'd0);
        chk("rst_done", 32'(line_done), 32'd0);
        chk("rst_lo", 32'(out_lo), 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic timing, unsigned base, map 0
        ld0 = n_ld;
        start_line(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        chk("t1_c1_adr", 32'(vram_adr), 32'h1800);
        chk("t1_c1_rd", 32'(vram_read), 32'd1);
        tick(1); chk("t1_c2_adr", 32'(vram_adr), 32'h0050);
        tick(1); chk("t1_c3_adr", 32'(vram_adr), 32'h0051);
        tick(1); chk("t1_c4_rd", 32'(vram_read), 32'd0);
        chk("t1_c4_valid", 32'(out_valid), 32'd0);
        tick(1); chk("t1_c5_valid", 32'(out_valid), 32'd1);
        chk("t1_c5_lo", 32'(out_lo), 32'hAA);
        chk("t1_c5_hi", 32'(out_hi), 32'h55);
        line_end(ld0);

        // Signed base, map 1
        ld0 = n_ld;
        start_line(8'd10, 8'd0, 8'd3, 1'b1, 1'b0);
        chk("t2_map_adr", 32'(vram_adr), 32'h1C20);
        tick(1); chk("t2_lo_adr", 32'(vram_adr), 32'h080A);
        tick(1); chk("t2_hi_adr", 32'(vram_adr), 32'h080B);
        tick(4); chk("t2_7f_lo_adr", 32'(vram_adr), 32'h17FA);
        line_end(ld0);

        // Column wrap and end of line
        ld0 = n_ld;
        start_line(8'h10, 8'hF8, 8'hFA, 1'b0, 1'b1);
        chk("t3_map0", 32'(vram_adr), 32'h183F);
        tick(5); chk("t3_map1", 32'(vram_adr), 32'h1820);
        tick(95); chk("t3_map20", 32'(vram_adr), 32'h1833);
        tick(5); chk("t3_done_hi", 32'(line_done), 32'd1);
        chk("t3_busy_lo", 32'(busy), 32'd0);
        tick(1); chk("t3_done_lo", 32'(line_done), 32'd0);
        tick(1);
        chk("t3_done_count", 32'(n_ld - ld0), 32'd1);

        // Backpressure in OUT
        ld0 = n_ld;
        out_ready = 1'b0;
        start_line(8'h22, 8'h10, 8'h05, 1'b0, 1'b1);
        tick(4);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_lo", 32'(out_lo), 32'(exp_lo[0]));
            chk("bp_hi", 32'(out_hi), 32'(exp_hi[0]));
            chk("bp_read", 32'(vram_read), 32'd0);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_next_map", 32'(vram_adr), 32'h1883);
        chk("bp_next_rd", 32'(vram_read), 32'd1);
        chk("bp_next_valid", 32'(out_valid), 32'd0);
        line_end(ld0);

        // Restart during HI of tile 7
        ld0 = n_ld;
        start_line(8'h30, 8'h00, 8'h00, 1'b0, 1'b1);
        tick(37);
        chk("rs_hi7_adr", 32'(vram_adr), 32'h0121);
        start_line(8'h30, 8'h28, 8'h00, 1'b0, 1'b1);
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_map_adr", 32'(vram_adr), 32'h18C5);
        chk("rs_map_rd", 32'(vram_read), 32'd1);
        line_end(ld0);

        // Asynchronous reset while in OUT
        ld0 = n_ld;
        out_ready = 1'b0;
        start_line(8'h44, 8'h18, 8'h02, 1'b0, 1'b1);
        tick(4);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_read", 32'(vram_read), 32'd0);
        chk("ar_adr", 32'(vram_adr), 32'd0);
        exp_rd.delete(); exp_lo.delete(); exp_hi.delete();
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        tick(3);
        chk("ar_idle", 32'(busy), 32'd0);
        chk("ar_no_done", 32'(n_ld - ld0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lr35902_bg_fetch.md
Name: lr35902_bg_fetch

Overview:
Background tile fetcher for the PPU. It is the read-side initiator on the 13-bit VRAM port. For one scanline it walks the BG tile map and fetches each tile's number, low bitplane and high bitplane from VRAM. Each fetched 8-pixel row is handed to the pixel pipeline over a valid/ready handshake.

Parameters:
TILES_PER_LINE, 21, tiles fetched per line (20 visible plus 1 for fine-scroll overlap); range 1..32.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin fetching a line (restarts if busy)
ly  in  8  current scanline
scx  in  8  horizontal scroll
scy  in  8  vertical scroll
map_sel  in  1  LCDC.3; 0 selects map 0x1800, 1 selects map 0x1C00 (VRAM-relative)
data_sel  in  1  LCDC.4; 1 selects unsigned 0x0000 tile base, 0 selects signed 0x1000 tile base
vram_adr  out  13  VRAM address
vram_read  out  1  VRAM read strobe; data appears on vram_dout the next cycle
vram_dout  in  8  VRAM registered read data
out_lo  out  8  bitplane 0 of fetched row, bit 7 = leftmost pixel
out_hi  out  8  bitplane 1 of fetched row
out_valid  out  1  row available
out_ready  in  1  consumer accepts row
busy  out  1  high in any state except IDLE
line_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (async): state IDLE; x=0; out_lo=out_hi=0; out_valid=0; line_done=0; vram_read=0; vram_adr=0.
- Latched at start: y = ly+scy (8-bit wrap); x0 = scx[7:3]. Latched inputs are held for the whole line. Later changes to ly, scx, scy, map_sel and data_sel are ignored until the next start.
- Tile column for the current tile: col = (x0 + x) mod 32, 5-bit wrap.
- Map address = {2'b11, map_sel, y[7:3], col}.
- Tile data address = {data_sel ? 1'b0 : ~t[7], t[7:0], y[2:0], b}, where t is the tile number and b is 0 for the low plane, 1 for the high plane.
- States:
  - IDLE: vram_read=0. On start, go to MAP.
  - MAP: vram_read=1, vram_adr=map address. Go to LO.
  - LO: latch t from vram_dout. vram_read=1, vram_adr=data address with b=0; t is taken combinationally from vram_dout this cycle. Go to HI.
  - HI: latch lo from vram_dout. vram_read=1, vram_adr=data address with b=1. Go to CAP.
  - CAP: vram_read=0. out_hi<=vram_dout, out_lo<=lo, out_valid<=1. Go to OUT.
  - OUT: hold out_lo, out_hi and out_valid stable until out_ready.
    - On out_ready while out_valid: clear out_valid; if x==TILES_PER_LINE-1, line_done<=1 and go to IDLE; otherwise x<=x+1 and go to MAP.
- Latency: start in cycle 0 gives MAP in cycle 1 and out_valid high from cycle 5. With out_ready tied high, there is one row every 5 cycles.
- vram_adr holds its last value whenever vram_read=0.
- start in any non-IDLE state aborts the line: relatch inputs, x=0, out_valid=0, go to MAP. No line_done is issued for the aborted line.
- start and an out_ready handshake in the same cycle: start wins.
- Reset asserted mid-line returns everything to the reset values immediately.
- out_ready while out_valid=0 is ignored.
- line_done is high for exactly one cycle.
- busy is combinational: busy = (state != IDLE).

Test Plan:
- Basic timing: reset, then start with ly=0, scx=0, scy=0, map_sel=0, data_sel=1, out_ready=1. Required cycle by cycle:
  - cycle 1: vram_adr=0x1800, read=1.
  - VRAM model returns tile 0x05.
  - cycle 2: adr=0x0050.
  - cycle 3: adr=0x0051.
  - Model returns 0xAA then 0x55: out_lo=0xAA, out_hi=0x55, valid in cycle 5.
- Signed base, map 1: map_sel=1, data_sel=0, ly=10, scy=3 (y=13), tile 0x80. Required: map adr=0x1C20, lo adr=0x080A, hi adr=0x080B. Tile 0x7F instead: lo adr=0x17FA.
- Wrap: scx=0xF8, scy=0xFA, ly=0x10 (y=0x0A). Required: first map adr=0x183F, second 0x1820. The 21st tile uses col 19 (adr 0x1833). line_done pulses once, then busy=0.
- Backpressure: hold out_ready=0 for 10 cycles in OUT. Required: out_valid and data stable, vram_read=0, x unchanged. Releasing out_ready gives MAP on the next cycle.
- Restart: pulse start mid-HI of tile 7. Required: out_valid=0, MAP next cycle at col x0, no line_done.
- Async reset: assert reset during OUT. Required: out_valid, busy and vram_read drop without waiting for a clock edge.
